// File: rtl/vip_hdmi_mon_pkg.sv
// Shared types and helpers for the HDMI frame monitor VIP.
package vip_hdmi_mon_pkg;

    localparam int ErrHPeriod = 0;
    localparam int ErrHWidth  = 1;
    localparam int ErrVPeriod = 2;
    localparam int ErrVWidth  = 3;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } mon_state_e;

    function automatic logic [31:0] sig_step(input logic [31:0] sig,
                                             input logic [7:0]  r,
                                             input logic [7:0]  g,
                                             input logic [7:0]  b);
        return {sig[30:0], sig[31]} ^ {8'h00, r, g, b};
    endfunction

endpackage

// File: rtl/vip_hdmi_mon_sync_chk.sv
// One sync axis: edge detect, saturating position counter, period and pulse-width checks.
// step_i qualifies every update, so the same block runs per cycle (H) or per line (V).
module vip_hdmi_mon_sync_chk #(
    parameter int unsigned Total = 800,
    parameter int unsigned Width = 96
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        step_i,
    input  logic        act_i,
    input  logic        chk_en_i,
    output logic        rise_o,
    output logic [15:0] cnt_o,
    output logic        err_period_o,
    output logic        err_width_o
);

    logic        act_q, act_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fall;

    always_comb begin
        act_d  = step_i ? act_i : act_q;
        rise_o = step_i & act_i & ~act_q;
        fall   = step_i & ~act_i & act_q;
        cnt_d  = cnt_q;
        if (rise_o) begin
            cnt_d = '0;
        end else if (step_i && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        // cnt_q is the position of the previous step; cnt_d is the position of this one
        err_period_o = chk_en_i & rise_o & (cnt_q != 16'(Total - 1));
        err_width_o  = chk_en_i & fall & (cnt_d != 16'(Width));
    end

    assign cnt_o = cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            act_q <= act_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vip_hdmi_frame_monitor.sv
// HDMI frame monitor: sync lock, timing checks, per-frame pixel signature and frame count.
module vip_hdmi_frame_monitor
    import vip_hdmi_mon_pkg::*;
#(
    parameter int unsigned HActive        = 640,
    parameter int unsigned HFrontPorch    = 16,
    parameter int unsigned HSyncLen       = 96,
    parameter int unsigned HBackPorch     = 48,
    parameter int unsigned VActive        = 480,
    parameter int unsigned VFrontPorch    = 10,
    parameter int unsigned VSyncLen       = 2,
    parameter int unsigned VBackPorch     = 33,
    parameter logic        SyncActiveHigh = 1'b1,
    parameter logic [31:0] CrcSeed        = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [7:0]  red_i,
    input  logic [7:0]  green_i,
    input  logic [7:0]  blue_i,
    input  logic        clr_err_i,
    output logic        lock_o,
    output logic        frame_done_o,
    output logic [31:0] frame_crc_o,
    output logic [15:0] frame_cnt_o,
    output logic [3:0]  err_o
);

    // state    | meaning
    // UNLOCKED | waiting for the first frame start; no checks, no signature
    // LOCKED   | timing checks armed, signature accumulated over active pixels

    localparam int unsigned HTotal = HSyncLen + HBackPorch + HActive + HFrontPorch;
    localparam int unsigned VTotal = VSyncLen + VBackPorch + VActive + VFrontPorch;
    localparam logic [15:0] HActLo = 16'(HSyncLen + HBackPorch);
    localparam logic [15:0] HActHi = 16'(HSyncLen + HBackPorch + HActive);
    localparam logic [15:0] VActLo = 16'(VSyncLen + VBackPorch);
    localparam logic [15:0] VActHi = 16'(VSyncLen + VBackPorch + VActive);

    mon_state_e  state_q;
    logic        lock_q;
    logic        hs_act, vs_act, h_edge, frame_start;
    logic [15:0] hcnt, vcnt;
    logic        h_err_per, h_err_wid, v_err_per, v_err_wid;
    logic        locked, pix_en, last_pix;
    logic [31:0] sig_q, sig_d, crc_q, crc_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]  err_q, err_d;
    logic        done_q, done_d;

    assign hs_act = (hsync_i == SyncActiveHigh);
    assign vs_act = (vsync_i == SyncActiveHigh);
    assign locked = (state_q == LOCKED);

    vip_hdmi_mon_sync_chk #(.Total(HTotal), .Width(HSyncLen)) u_h_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .step_i      (1'b1),
        .act_i       (hs_act),
        .chk_en_i    (locked),
        .rise_o      (h_edge),
        .cnt_o       (hcnt),
        .err_period_o(h_err_per),
        .err_width_o (h_err_wid)
    );

    // vsync is only looked at on hsync edges, so V counts lines
    vip_hdmi_mon_sync_chk #(.Total(VTotal), .Width(VSyncLen)) u_v_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .step_i      (h_edge),
        .act_i       (vs_act),
        .chk_en_i    (locked),
        .rise_o      (frame_start),
        .cnt_o       (vcnt),
        .err_period_o(v_err_per),
        .err_width_o (v_err_wid)
    );

    assign pix_en = locked && hcnt >= HActLo && hcnt < HActHi
                           && vcnt >= VActLo && vcnt < VActHi;
    assign last_pix = pix_en && hcnt == HActHi - 16'd1 && vcnt == VActHi - 16'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= UNLOCKED;
            lock_q  <= 1'b0;
        end else if (state_q == UNLOCKED && frame_start) begin
            state_q <= LOCKED;
            lock_q  <= 1'b1;
        end
    end

    always_comb begin
        sig_d       = sig_q;
        crc_d       = crc_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        if (frame_start) begin
            sig_d = CrcSeed;
        end else if (pix_en) begin
            sig_d = sig_step(sig_q, red_i, green_i, blue_i);
        end
        if (last_pix) begin
            crc_d       = sig_d;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        // a new error in the clear cycle survives
        err_d             = clr_err_i ? 4'b0000 : err_q;
        err_d[ErrHPeriod] = err_d[ErrHPeriod] | h_err_per;
        err_d[ErrHWidth]  = err_d[ErrHWidth]  | h_err_wid;
        err_d[ErrVPeriod] = err_d[ErrVPeriod] | v_err_per;
        err_d[ErrVWidth]  = err_d[ErrVWidth]  | v_err_wid;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q       <= CrcSeed;
            crc_q       <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            sig_q       <= sig_d;
            crc_q       <= crc_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign lock_o       = lock_q;
    assign frame_done_o = done_q;
    assign frame_crc_o  = crc_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_vip_hdmi_frame_monitor.sv
// Scoreboard bench for vip_hdmi_frame_monitor on a small 15x8 timing.
module tb_vip_hdmi_frame_monitor;

    localparam int HA = 8, HFP = 2, HSY = 3, HBP = 2, HTOT = 15;
    localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1, VTOT = 8;
    localparam int HX0 = HSY + HBP;
    localparam int VY0 = VSY + VBP;
    localparam logic [31:0] SEED = 32'hFFFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        hsync_i = 1'b0, vsync_i = 1'b0, clr_err_i = 1'b0;
    logic [7:0]  red_i = '0, green_i = '0, blue_i = '0;
    logic        lock_o, frame_done_o;
    logic [31:0] frame_crc_o;
    logic [15:0] frame_cnt_o;
    logic [3:0]  err_o;

    typedef struct packed {
        logic [31:0] crc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0, bad = 0, done_seen = 0, d0;
    logic [15:0] exp_cnt = '0;

    vip_hdmi_frame_monitor #(
        .HActive(HA), .HFrontPorch(HFP), .HSyncLen(HSY), .HBackPorch(HBP),
        .VActive(VA), .VFrontPorch(VFP), .VSyncLen(VSY), .VBackPorch(VBP),
        .SyncActiveHigh(1'b1), .CrcSeed(SEED)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .red_i(red_i), .green_i(green_i), .blue_i(blue_i), .clr_err_i(clr_err_i),
        .lock_o(lock_o), .frame_done_o(frame_done_o), .frame_crc_o(frame_crc_o),
        .frame_cnt_o(frame_cnt_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (frame_done_o === 1'b1) begin
            done_seen++;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("frame_crc", frame_crc_o, e.crc);
                chk("frame_cnt", 32'(frame_cnt_o), 32'(e.cnt));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        hsync_i = 1'b0; vsync_i = 1'b0; clr_err_i = 1'b0;
        {red_i, green_i, blue_i} = '0;
        idle(2);
        rst_ni = 1'b1;
        exp_cnt = '0;
        sb.delete();
        idle(1);
    endtask

    // mode 0: zeros, 1: single 1 in first active pixel, 2: random pixels
    task automatic drive_frame(input int mode, input int l0, input int l1, input int vsl,
                               input int bad_l, input int bper, input int bwid, input bit push);
        logic [31:0] sig;
        logic [23:0] px;
        int          per, wid;
        sig = SEED;
        for (int l = l0; l <= l1; l++) begin
            per = (l == bad_l) ? bper : HTOT;
            wid = (l == bad_l) ? bwid : HSY;
            for (int x = 0; x < per; x++) begin
                hsync_i = (x < wid);
                vsync_i = (l < vsl);
                px = '0;
                if (l >= VY0 && l < VY0 + VA && x >= HX0 && x < HX0 + HA) begin
                    if (mode == 1) px = (l == VY0 && x == HX0) ? 24'h000001 : 24'h000000;
                    else if (mode == 2) px = 24'($urandom);
                    sig = {sig[30:0], sig[31]} ^ {8'h00, px};
                    if (push && l == VY0 + VA - 1 && x == HX0 + HA - 1) begin
                        exp_cnt = exp_cnt + 16'd1;
                        sb.push_back('{crc: sig, cnt: exp_cnt});
                    end
                end
                {red_i, green_i, blue_i} = px;
                @(posedge clk_i); #1;
            end
        end
        hsync_i = 1'b0; vsync_i = 1'b0;
        {red_i, green_i, blue_i} = '0;
    endtask

    task automatic lead_in();
        drive_frame(0, VY0, VTOT - 1, VSY, -1, 0, 0, 1'b0);
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_lock", 32'(lock_o), 32'd0);
        chk("rst_done", 32'(frame_done_o), 32'd0);
        chk("rst_crc", frame_crc_o, 32'd0);
        chk("rst_cnt", 32'(frame_cnt_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        do_reset();

        // zero pixels: lock after first frame start, two completions
        d0 = done_seen;
        lead_in();
        chk("lock_pre", 32'(lock_o), 32'd0);
        drive_frame(0, 0, VTOT - 1, VSY, -1, 0, 0, 1'b1);
        chk("lock_post", 32'(lock_o), 32'd1);
        drive_frame(0, 0, VTOT - 1, VSY, -1, 0, 0, 1'b1);
        idle(5);
        chk("done_count", 32'(done_seen - d0), 32'd2);
        chk("crc_zero", frame_crc_o, 32'hFFFF_FFFF);
        chk("err_clean", 32'(err_o), 32'd0);
        chk("cnt_two", 32'(frame_cnt_o), 32'd2);
        chk("sb_empty1", 32'(sb.size()), 32'd0);

        // single-pixel and random frames
        do_reset();
        lead_in();
        drive_frame(1, 0, VTOT - 1, VSY, -1, 0, 0, 1'b1);
        chk("crc_one", frame_crc_o, 32'h7FFF_FFFF);
        drive_frame(2, 0, VTOT - 1, VSY, -1, 0, 0, 1'b1);
        drive_frame(2, 0, VTOT - 1, VSY, -1, 0, 0, 1'b1);
        idle(5);
        chk("err_rand", 32'(err_o), 32'd0);
        chk("sb_empty2", 32'(sb.size()), 32'd0);

        // short line -> HPERIOD, sticky until clear
        do_reset();
        lead_in();
        drive_frame(0, 0, VTOT - 1, VSY, 4, HTOT - 1, HSY, 1'b1);
        idle(4);
        chk("err_hper", 32'(err_o), 32'd1);
        idle(10);
        chk("err_sticky", 32'(err_o), 32'd1);
        clr_err_i = 1'b1;
        idle(1);
        clr_err_i = 1'b0;
        chk("err_clr", 32'(err_o), 32'd0);
        chk("sb_empty3", 32'(sb.size()), 32'd0);

        // hsync width 4 -> HWIDTH
        do_reset();
        lead_in();
        drive_frame(0, 0, VTOT - 1, VSY, 5, HTOT, HSY + 1, 1'b1);
        idle(4);
        chk("err_hwid", 32'(err_o), 32'd2);

        // vsync width 3 lines -> VWIDTH
        do_reset();
        lead_in();
        drive_frame(2, 0, VTOT - 1, VSY + 1, -1, 0, 0, 1'b1);
        idle(4);
        chk("err_vwid", 32'(err_o), 32'd8);
        chk("sb_empty4", 32'(sb.size()), 32'd0);

        // frame restart after line 5 -> VPERIOD, partial frame dropped
        do_reset();
        lead_in();
        d0 = done_seen;
        drive_frame(2, 0, 5, VSY, -1, 0, 0, 1'b0);
        drive_frame(2, 0, VTOT - 1, VSY, -1, 0, 0, 1'b1);
        idle(4);
        chk("err_vper", 32'(err_o), 32'd4);
        chk("done_partial", 32'(done_seen - d0), 32'd1);
        chk("sb_empty5", 32'(sb.size()), 32'd0);

        // reset mid active line, relock, counter wrap
        do_reset();
        lead_in();
        drive_frame(0, 0, VTOT - 1, VSY, -1, 0, 0, 1'b1);
        drive_frame(0, 0, 3, VSY, -1, 0, 0, 1'b0);
        drive_frame(0, 4, 4, VSY, 4, HX0 + 3, HSY, 1'b0);
        chk("pre_rst_cnt", 32'(frame_cnt_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_lock", 32'(lock_o), 32'd0);
        chk("mid_rst_done", 32'(frame_done_o), 32'd0);
        chk("mid_rst_crc", frame_crc_o, 32'd0);
        chk("mid_rst_cnt", 32'(frame_cnt_o), 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        sb.delete();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        exp_cnt = '0;
        lead_in();
        chk("relock_pre", 32'(lock_o), 32'd0);
        force dut.frame_cnt_q = 16'hFFFF;
        idle(1);
        release dut.frame_cnt_q;
        exp_cnt = 16'hFFFF;
        drive_frame(2, 0, VTOT - 1, VSY, -1, 0, 0, 1'b1);
        chk("relock_post", 32'(lock_o), 32'd1);
        idle(5);
        chk("cnt_wrap", 32'(frame_cnt_o), 32'd0);
        chk("sb_empty6", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
